// File: rtl/iis_recv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : iis_recv
//  Purpose  : I2S slave receiver. Oversamples SCK/WS/SD in the clk domain,
//             deserialises MSB-first words tagged left/right into a small FIFO.
//  Option   : IIS_RECV_ERRCHK_EN adds a per-entry frame-error tag (rd_err)
//             and a sticky frame_err flag.
//  Revision : 1.0  initial release
// ============================================================================
module iis_recv #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [1:0]                   rx_ctrl,
    input  logic                         sck_in,
    input  logic                         ws_in,
    input  logic                         sd_in,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_chan,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow
`ifdef IIS_RECV_ERRCHK_EN
    ,
    output logic                         rd_err,
    output logic                         frame_err
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   PTR_FULL = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef IIS_RECV_ERRCHK_EN
    localparam int ENTRY_W = DATA_W + 2;
`else
    localparam int ENTRY_W = DATA_W + 1;
`endif

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    logic enable;
    logic clear;
    assign enable = rx_ctrl[0];
    assign clear  = rx_ctrl[1];

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   ws_prev_q, ws_prev_d;
    logic                   sck_s, ws_s, sd_s, sck_rise, boundary;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d, shift_new;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d, cnt_new;
    logic                   push_q, push_d;
    logic [DATA_W-1:0]      push_word_q, push_word_d;
    logic                   push_chan_q, push_chan_d;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d;
    logic [ENTRY_W-1:0]     head, wr_entry;
    logic                   full, wr_en, pop, accept;

`ifdef IIS_RECV_ERRCHK_EN
    logic                   long_q, long_d, long_new;
    logic                   push_err_q, push_err_d;
    logic                   frame_err_q, frame_err_d;
`endif

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck_in};
        ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], ws_in};
        sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], sd_in};
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign ws_s       = ws_sync_q[SYNC_STAGES-1];
    assign sd_s       = sd_sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_hist_q;
    assign boundary   = sck_rise & (ws_s != ws_prev_q);
    assign sck_hist_d = sck_s;

    // Receive state machine and deserialiser; ws_prev tracks the line even when disabled
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ws_prev_d   = sck_rise ? ws_s : ws_prev_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        push_chan_d = push_chan_q;
        shift_new   = shift_q;
        cnt_new     = bit_cnt_q;
`ifdef IIS_RECV_ERRCHK_EN
        long_d      = long_q;
        long_new    = long_q | (sck_rise & (bit_cnt_q == CNT_FULL));
        push_err_d  = push_err_q;
`endif
        if (sck_rise && (bit_cnt_q < CNT_FULL)) begin
            shift_new = {shift_q[DATA_W-2:0], sd_s};
            cnt_new   = bit_cnt_q + CNT_ONE;
        end

        if (!enable) begin
            state_d   = ST_DISABLED;
            bit_cnt_d = '0;
`ifdef IIS_RECV_ERRCHK_EN
            long_d    = 1'b0;
`endif
        end else if (state_q == ST_DISABLED) begin
            state_d   = ST_ALIGN;
            bit_cnt_d = '0;
`ifdef IIS_RECV_ERRCHK_EN
            long_d    = 1'b0;
`endif
        end else if (sck_rise) begin
            shift_d   = shift_new;
            bit_cnt_d = cnt_new;
`ifdef IIS_RECV_ERRCHK_EN
            long_d    = long_new;
`endif
            if (boundary) begin
                shift_d   = '0;
                bit_cnt_d = '0;
`ifdef IIS_RECV_ERRCHK_EN
                long_d    = 1'b0;
`endif
                if (state_q == ST_ALIGN) begin
                    state_d = ST_RUN;
                end else begin
                    push_d      = ~clear;
                    push_word_d = shift_new << (CNT_FULL - cnt_new);
                    push_chan_d = ws_prev_q;
`ifdef IIS_RECV_ERRCHK_EN
                    push_err_d  = (cnt_new != CNT_FULL) | long_new;
`endif
                end
            end
        end
    end

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign full       = (fifo_level == PTR_FULL);
    assign rd_valid   = (fifo_level != '0);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign pop        = rd_valid & rd_ready;
    assign wr_en      = push_q;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign accept     = wr_en & (~full | pop);

`ifdef IIS_RECV_ERRCHK_EN
    assign wr_entry   = {push_err_q, push_chan_q, push_word_q};
`else
    assign wr_entry   = {push_chan_q, push_word_q};
`endif

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (accept) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = wr_entry;
                wr_ptr_d                   = wr_ptr_q + PTR_ONE;
            end else if (wr_en) begin
                overflow_d = 1'b1;
            end
        end
    end

`ifdef IIS_RECV_ERRCHK_EN
    always_comb begin
        frame_err_d = frame_err_q | (wr_en & push_err_q);
        if (clear) begin
            frame_err_d = 1'b0;
        end
    end

    assign rd_err    = rd_valid & head[DATA_W+1];
    assign frame_err = frame_err_q;
`endif

    assign rd_data  = rd_valid ? head[DATA_W-1:0] : '0;
    assign rd_chan  = rd_valid & head[DATA_W];
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync_q  <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            sck_hist_q  <= 1'b0;
            ws_prev_q   <= 1'b0;
            state_q     <= ST_DISABLED;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            push_chan_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
`ifdef IIS_RECV_ERRCHK_EN
            long_q      <= 1'b0;
            push_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            sck_sync_q  <= sck_sync_d;
            ws_sync_q   <= ws_sync_d;
            sd_sync_q   <= sd_sync_d;
            sck_hist_q  <= sck_hist_d;
            ws_prev_q   <= ws_prev_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            push_chan_q <= push_chan_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
`ifdef IIS_RECV_ERRCHK_EN
            long_q      <= long_d;
            push_err_q  <= push_err_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // Storage needs no reset: every read path is gated by rd_valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire
